keypad_matrix_scanner: RTL and testbench
========================================

# keypad_matrix_scanner

Scans a 4×4 push-button keypad by driving one column low at a time and reading the four row lines. Debounces key press and key release, then delivers one 4-bit key code per press through a single-entry valid/ack buffer. It is the input-side counterpart of the LED matrix column scanner and feeds operator commands (irrigation mode, manual fill, reset requests) into the irrigation controller FSMs.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column stays driven. Must be ≥ 4.
- `DEBOUNCE`, default 4: number of consecutive identical scan samples needed to accept a press or a release. Must be ≥ 1.
- `clock`  in  1: single clock for the whole block.
- `reset`  in  1: synchronous, active-high. Sampled on the rising edge of `clock`.
- `key_col`  out  4: column drive, active-low, exactly one bit low.
- `key_row`  in  4: row sense, active-low (rows are pulled up externally), asynchronous.
- `key_code`  out  4: accepted key, coded as {col_idx[1:0], row_idx[1:0]}.
- `key_valid`  out  1: `key_code` holds an unconsumed key.
- `key_ack`  in  1: the consumer has taken `key_code`.
- `key_held`  out  1: a debounced key is currently pressed.
- `overrun`  out  1: sticky; a key was lost because the buffer was full.

## Operation
- **Row synchronizer:** `key_row` passes through two flip-flops before any use.
- **Tick:** a divider counts 0..SCAN_DIV-1. `tick` is high when the count is SCAN_DIV-1. The synchronized rows are sampled only on `tick`.
- **Column drive:** `col_idx` advances 0→1→2→3→0 on `tick`, but only in SCAN state. `key_col = ~(4'b0001 << col_idx)`.
- **Row priority:** if several rows are low, the lowest-index low row is the pressed row.
- **SCAN:**
  - On `tick`, if any sampled row is low: capture `row_idx`, freeze `col_idx`, set `deb_cnt = 1`, go to DEBOUNCE.
  - Otherwise advance the column.
- **DEBOUNCE:** on each `tick`:
  - If the captured row is still low, increment `deb_cnt`.
  - When `deb_cnt` reaches DEBOUNCE: emit the code, go to HELD.
  - If the captured row is high: go to SCAN and advance the column. No emit.
  - DEBOUNCE = 1 means the code is emitted on the first capture tick, going directly SCAN→HELD.
- **HELD:** `key_held = 1`. On `tick`, if the captured row is high: set `deb_cnt = 1` and go to RELEASE.
- **RELEASE:** `key_held` stays 1. On each `tick`:
  - If the captured row is high, increment `deb_cnt`.
  - When `deb_cnt` reaches DEBOUNCE: go to SCAN and advance the column.
  - If the row goes low again: go back to HELD. No new emit.
- **Auto-repeat:** none. One emit per accepted press.
- **Emit and buffer:**
  - Emit with `key_valid = 0`, or with `key_ack = 1` in the same cycle: load `key_code`, `key_valid = 1`.
  - Emit with `key_valid = 1` and no `key_ack`: keep the old code, set `overrun = 1`.
  - `key_ack` with no emit: `key_valid = 0`. `key_code` keeps its last value.
  - `key_ack` while `key_valid = 0`: ignored.
- **overrun** is cleared only by `reset`.
- **Reset**, including mid-scan or mid-debounce:
  - state = SCAN, `col_idx = 0`, so `key_col = 4'b1110`.
  - divider = 0, `deb_cnt = 0`, synchronizer = 4'b1111.
  - `key_code = 0`, `key_valid = 0`, `key_held = 0`, `overrun = 0`.
  - A key held through reset is re-debounced from scratch.

## Timing
- All outputs are registered. No combinational path from `key_row` or `key_ack` to any output.
- Row input to sampled value: 2 cycles of synchronizer latency. With SCAN_DIV ≥ 4, rows settle within one dwell period.
- Press latency: `key_valid` rises the cycle after the DEBOUNCE-th consecutive low sample. This is the (DEBOUNCE-1)-th tick after the capture tick.
- `key_held` rises together with `key_valid` for that press. It falls the cycle after the DEBOUNCE-th consecutive high sample.
- `key_valid` falls the cycle after the `key_ack` edge.
- Full sweep of all four columns with no key pressed: 4·SCAN_DIV cycles.

## Structure
- Package `keypad_pkg`:
  - state enum {SCAN, DEBOUNCE, HELD, RELEASE};
  - `NUM_COLS = 4`, `NUM_ROWS = 4`, `CODE_W = 4`;
  - a function returning the lowest-index low row.
- Sub-module `scan_tick_gen`: parameterized modulo-SCAN_DIV counter with a one-cycle `tick` output and a synchronous reset.
- The FSM, synchronizer and buffer live in the top module.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE = 3.
- **Idle after reset:** release reset with all rows high → `key_col` cycles 1110→1101→1011→0111 every 4 cycles; `key_valid = 0`, `key_held = 0`.
- **Clean press:** hold row 2 low only while column 1 is driven, for 20 cycles, then release → exactly one `key_code = 4'h6` with `key_valid = 1`; `key_held` high until 3 released ticks; scanning resumes at column 2.
- **Bounce:** toggle row 0 every tick on column 3 for 4 ticks, then hold it low → no emit during bouncing; single `key_code = 4'hC` after 3 stable ticks.
- **Overrun:** two accepted presses (4'h0, then 4'h5) without `key_ack` → `key_code` stays 4'h0, `overrun = 1`; after `key_ack`, `key_valid = 0` and `overrun` stays 1.
- **Ack on emit cycle:** `key_ack` pulsed on the same cycle a new code 4'hF is emitted → `key_valid` stays 1, `key_code = 4'hF`, `overrun = 0`.
- **Reset mid-debounce:** assert `reset` for 1 cycle during DEBOUNCE of row 1 → all outputs return to reset values next cycle; the held key is re-emitted only after a full new 3-tick debounce.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, keypad geometry and the row-priority helper
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int CODE_W   = 4;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    function automatic logic [1:0] low_row(input logic [NUM_ROWS-1:0] rows);
        return !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_tick.sv
// scan_tick_gen: free-running modulo-DIV counter with a one-cycle terminal-count tick
module scan_tick_gen #(
    parameter int DIV = 1000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(DIV - 1);

    always_ff @(posedge clock) begin
        if (reset || tick)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: 4x4 keypad column scan with press/release debounce and a one-entry key buffer
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic                clock,
    input  logic                reset,
    output logic [NUM_COLS-1:0] key_col,
    input  logic [NUM_ROWS-1:0] key_row,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    input  logic                key_ack,
    output logic                key_held,
    output logic                overrun
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);

    state_t              state;
    logic [NUM_ROWS-1:0] row_meta, row_s;
    logic [1:0]          col_idx, row_idx;
    logic [DW-1:0]       deb_cnt;
    logic                tick, any_low, row_low, emit;

    scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            row_meta <= '1;
            row_s    <= '1;
        end else begin
            row_meta <= key_row;
            row_s    <= row_meta;
        end
    end

    assign any_low = ~&row_s;
    assign row_low = ~row_s[row_idx];
    // A single-sample debounce accepts the key straight from SCAN
    assign emit = tick && ((state == SCAN && any_low && DEBOUNCE == 1) ||
                           (state == keypad_pkg::DEBOUNCE && row_low && deb_cnt == DEB_LAST));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= SCAN;
            col_idx  <= '0;
            key_col  <= 4'b1110;
            row_idx  <= '0;
            deb_cnt  <= '0;
            key_held <= 1'b0;
        end else if (tick) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        row_idx  <= low_row(row_s);
                        deb_cnt  <= DW'(1);
                        state    <= (DEBOUNCE == 1) ? HELD : keypad_pkg::DEBOUNCE;
                        key_held <= DEBOUNCE == 1;
                    end else begin
                        col_idx <= col_idx + 2'd1;
                        key_col <= {key_col[2:0], key_col[3]};
                    end
                end
                keypad_pkg::DEBOUNCE: begin
                    if (!row_low) begin
                        state   <= SCAN;
                        col_idx <= col_idx + 2'd1;
                        key_col <= {key_col[2:0], key_col[3]};
                    end else if (deb_cnt == DEB_LAST) begin
                        state    <= HELD;
                        key_held <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                HELD: begin
                    if (!row_low) begin
                        deb_cnt <= DW'(1);
                        if (DEBOUNCE == 1) begin
                            state    <= SCAN;
                            key_held <= 1'b0;
                            col_idx  <= col_idx + 2'd1;
                            key_col  <= {key_col[2:0], key_col[3]};
                        end else begin
                            state <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (row_low) begin
                        state <= HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        state    <= SCAN;
                        key_held <= 1'b0;
                        col_idx  <= col_idx + 2'd1;
                        key_col  <= {key_col[2:0], key_col[3]};
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (emit) begin
            if (!key_valid || key_ack) begin
                key_code  <= {col_idx, (state == SCAN) ? low_row(row_s) : row_idx};
                key_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (key_ack) begin
            key_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed scenarios on a modelled 4x4 keypad, SCAN_DIV=4, DEBOUNCE=3
module tb_keypad_matrix_scanner;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        key_ack = 1'b0;
    logic [3:0]  key_col, key_row, key_code;
    logic        key_valid, key_held, overrun;
    logic [15:0] pressed = '0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .key_col  (key_col),
        .key_row  (key_row),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ack  (key_ack),
        .key_held (key_held),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

    // Key (c,r) at index c*4+r shorts row r to column c when that column is driven low
    always_comb begin
        key_row = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[c*4+r] && !key_col[c]) key_row[r] = 1'b0;
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests++; if (key_col !== 4'b1110) begin fails++; $display("FAIL reset_col: got %b want 1110", key_col); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        tests++; if (key_held !== 1'b0) begin fails++; $display("FAIL reset_held: got %b want 0", key_held); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_code: got %h want 0", key_code); end
        reset = 1'b0;
    endtask

    task automatic test_idle;
        logic [3:0] one, exp;
        one = 4'b0001;
        for (int i = 1; i <= 16; i++) begin
            wait_until(i);
            exp = ~(one << ((i / 4) % 4));
            tests++; if (key_col !== exp) begin fails++; $display("FAIL idle_col cyc %0d: got %b want %b", i, key_col, exp); end
            tests++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin fails++; $display("FAIL idle_flags cyc %0d: got valid %b held %b want 0 0", i, key_valid, key_held); end
        end
    endtask

    task automatic test_clean_press;
        wait_until(16);
        pressed[6] = 1'b1;
        wait_until(31);
        tests++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin fails++; $display("FAIL press_early: got valid %b held %b want 0 0", key_valid, key_held); end
        wait_until(32);
        tests++; if (key_valid !== 1'b1 || key_code !== 4'h6) begin fails++; $display("FAIL press_emit: got valid %b code %h want 1 6", key_valid, key_code); end
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL press_held: got %b want 1", key_held); end
        key_ack = 1'b1;
        wait_until(33);
        key_ack = 1'b0;
        tests++; if (key_valid !== 1'b0 || key_code !== 4'h6) begin fails++; $display("FAIL press_ack: got valid %b code %h want 0 6", key_valid, key_code); end
        wait_until(36);
        pressed[6] = 1'b0;
        wait_until(47);
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL release_early: got held %b want 1", key_held); end
        wait_until(48);
        tests++; if (key_held !== 1'b0 || key_col !== 4'b1011) begin fails++; $display("FAIL release_done: got held %b col %b want 0 1011", key_held, key_col); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL release_no_reemit: got valid %b want 0", key_valid); end
    endtask

    task automatic test_bounce;
        for (int n = 49; n <= 83; n++) begin
            wait_until(n);
            if (n == 50 || n == 61 || n == 69) pressed[12] = 1'b1;
            if (n == 57 || n == 65) pressed[12] = 1'b0;
            tests++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin fails++; $display("FAIL bounce_quiet cyc %0d: got valid %b held %b want 0 0", n, key_valid, key_held); end
        end
        wait_until(84);
        tests++; if (key_valid !== 1'b1 || key_code !== 4'hC) begin fails++; $display("FAIL bounce_emit: got valid %b code %h want 1 c", key_valid, key_code); end
    endtask

    task automatic test_ack_on_emit;
        pressed[12] = 1'b0;
        wait_until(96);
        tests++; if (key_held !== 1'b0 || key_col !== 4'b1110) begin fails++; $display("FAIL c_release: got held %b col %b want 0 1110", key_held, key_col); end
        pressed[15] = 1'b1;
        wait_until(119);
        tests++; if (key_valid !== 1'b1 || key_code !== 4'hC) begin fails++; $display("FAIL pre_emit: got valid %b code %h want 1 c", key_valid, key_code); end
        key_ack = 1'b1;
        wait_until(120);
        key_ack = 1'b0;
        tests++; if (key_valid !== 1'b1 || key_code !== 4'hF) begin fails++; $display("FAIL ack_emit: got valid %b code %h want 1 f", key_valid, key_code); end
        tests++; if (overrun !== 1'b0 || key_held !== 1'b1) begin fails++; $display("FAIL ack_emit_flags: got overrun %b held %b want 0 1", overrun, key_held); end
        pressed[15] = 1'b0;
    endtask

    task automatic test_overrun;
        wait_until(121);
        key_ack = 1'b1;
        wait_until(122);
        key_ack = 1'b0;
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL f_ack: got valid %b want 0", key_valid); end
        wait_until(132);
        tests++; if (key_held !== 1'b0 || key_col !== 4'b1110) begin fails++; $display("FAIL f_release: got held %b col %b want 0 1110", key_held, key_col); end
        pressed[0] = 1'b1;
        wait_until(144);
        tests++; if (key_valid !== 1'b1 || key_code !== 4'h0 || overrun !== 1'b0) begin fails++; $display("FAIL first_key: got valid %b code %h overrun %b want 1 0 0", key_valid, key_code, overrun); end
        pressed[0] = 1'b0;
        pressed[5] = 1'b1;
        wait_until(167);
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_early: got %b want 0", overrun); end
        wait_until(168);
        tests++; if (overrun !== 1'b1 || key_code !== 4'h0 || key_valid !== 1'b1) begin fails++; $display("FAIL overrun_set: got overrun %b code %h valid %b want 1 0 1", overrun, key_code, key_valid); end
        key_ack = 1'b1;
        wait_until(169);
        key_ack = 1'b0;
        tests++; if (key_valid !== 1'b0 || overrun !== 1'b1 || key_code !== 4'h0) begin fails++; $display("FAIL overrun_sticky: got valid %b overrun %b code %h want 0 1 0", key_valid, overrun, key_code); end
        pressed[5] = 1'b0;
        wait_until(179);
        tests++; if (key_held !== 1'b1) begin fails++; $display("FAIL key5_held: got %b want 1", key_held); end
        wait_until(180);
        tests++; if (key_held !== 1'b0 || key_col !== 4'b1011) begin fails++; $display("FAIL key5_release: got held %b col %b want 0 1011", key_held, key_col); end
    endtask

    task automatic test_reset_mid_debounce;
        pressed[9] = 1'b1;
        wait_until(185);
        reset = 1'b1;
        @(negedge clock);
        tests++; if (key_col !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0) begin fails++; $display("FAIL mid_reset: got col %b valid %b held %b want 1110 0 0", key_col, key_valid, key_held); end
        tests++; if (overrun !== 1'b0 || key_code !== 4'h0) begin fails++; $display("FAIL mid_reset_buf: got overrun %b code %h want 0 0", overrun, key_code); end
        reset = 1'b0;
        wait_until(19);
        tests++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin fails++; $display("FAIL redeb_early: got valid %b held %b want 0 0", key_valid, key_held); end
        wait_until(20);
        tests++; if (key_valid !== 1'b1 || key_code !== 4'h9 || key_held !== 1'b1) begin fails++; $display("FAIL redeb_emit: got valid %b code %h held %b want 1 9 1", key_valid, key_code, key_held); end
        pressed[9] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_idle;
        test_clean_press;
        test_bounce;
        test_ack_on_emit;
        test_overrun;
        test_reset_mid_debounce;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
